spi_cmd_scheduler: RTL

SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

---
 rtl/spi_cmd_scheduler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: decodes SPI command words, drives a GCD engine through a
// three-state FSM, buffers pixels for a Sobel filter in a small FIFO, and
// round-robin arbitrates GCD and Sobel results into a single response slot.
// Optional GCD watchdog: define SPI_SCHED_TIMEOUT_EN to enable it.
module spi_cmd_scheduler #(
  parameter int DATA_WIDTH     = 12,
  parameter int PIXEL_WIDTH    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   cmd_valid_i,
  input  logic [15:0]            cmd_data_i,
  output logic [DATA_WIDTH-1:0]  operand_a_o,
  output logic [DATA_WIDTH-1:0]  operand_b_o,
  output logic                   gcd_enable_o,
  input  logic [DATA_WIDTH-1:0]  gcd_i,
  input  logic                   gcd_done_i,
  output logic                   pixel_valid_o,
  output logic [PIXEL_WIDTH-1:0] pixel_o,
  input  logic                   pixel_ready_i,
  input  logic [PIXEL_WIDTH-1:0] sobel_px_i,
  input  logic                   sobel_px_valid_i,
  output logic [15:0]            tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ack_i,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_RUN    = 2'd1,
    G_RESULT = 2'd2
  } gcd_state_t;

  gcd_state_t g_state;

  // ---------------------------------------------------------------- decode
  logic is_ctrl, px_push, load_a, load_b, start_cmd, clear_cmd;

  assign is_ctrl   = cmd_valid_i & ~cmd_data_i[15];
  assign px_push   = cmd_valid_i &  cmd_data_i[15];
  assign load_a    = is_ctrl & (cmd_data_i[14:13] == 2'b00);
  assign load_b    = is_ctrl & (cmd_data_i[14:13] == 2'b01);
  assign start_cmd = is_ctrl & (cmd_data_i[14:13] == 2'b10);
  assign clear_cmd = is_ctrl & (cmd_data_i[14:13] == 2'b11);

  // Bits of the command word that no decode path looks at.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_data_i;

  // Operand registers, loaded straight from the command word.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      operand_a_o <= '0;
      operand_b_o <= '0;
    end else begin
      if (load_a) operand_a_o <= cmd_data_i[DATA_WIDTH-1:0];
      if (load_b) operand_b_o <= cmd_data_i[DATA_WIDTH-1:0];
    end
  end

  // ------------------------------------------------------------ pixel FIFO
  logic [PIXEL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [PTR_W:0]         fifo_count;
  logic                   fifo_full, fifo_pop, fifo_push_ok, fifo_drop;

  assign fifo_full     = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign pixel_valid_o = (fifo_count != '0);
  assign fifo_pop      = pixel_valid_o & pixel_ready_i;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign fifo_push_ok  = px_push & (~fifo_full | fifo_pop);
  assign fifo_drop     = px_push & fifo_full & ~fifo_pop;
  // Gate the head so the output reads 0 whenever nothing is buffered.
  assign pixel_o       = pixel_valid_o ? fifo_mem[rd_ptr] : '0;

  // Pixel storage array.
  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count and the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (fifo_push_ok) fifo_mem[wr_ptr] <= cmd_data_i[PIXEL_WIDTH-1:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_push_ok && !fifo_pop)      fifo_count <= fifo_count + (PTR_W+1)'(1);
      else if (fifo_pop && !fifo_push_ok) fifo_count <= fifo_count - (PTR_W+1)'(1);
    end
  end

  // --------------------------------------------------------------- arbiter
  logic                   sob_pend, last_gcd;
  logic [PIXEL_WIDTH-1:0] sob_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   gcd_req, slot_free, grant_gcd, grant_sob, sob_drop;
  logic [15:0]            gcd_word, sob_word;

  assign gcd_req   = (g_state == G_RESULT);
  assign slot_free = ~tx_valid_o | tx_ack_i;
  // last_gcd=1 means GCD won the previous grant, so Sobel wins a tie now.
  assign grant_gcd = slot_free & gcd_req  & (~sob_pend | ~last_gcd);
  assign grant_sob = slot_free & sob_pend & (~gcd_req  |  last_gcd);
  assign sob_drop  = sobel_px_valid_i & sob_pend & ~grant_sob;

  // Response word formats for the two sources.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gcd_word                   = '0;
    gcd_word[DATA_WIDTH-1:0]   = result_q;
    sob_word                   = '0;
    sob_word[15]               = 1'b1;
    sob_word[PIXEL_WIDTH-1:0]  = sob_q;
  end

  // One-entry Sobel holding register; a new pixel overwrites an ungranted one.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sob_pend <= 1'b0;
      sob_q    <= '0;
    end else begin
      if (grant_sob) sob_pend <= 1'b0;
      if (sobel_px_valid_i) begin
        sob_pend <= 1'b1;
        sob_q    <= sobel_px_i;
      end
    end
  end

  // Response slot: refilled in the same cycle it is freed.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      last_gcd   <= 1'b0;
    end else if (grant_gcd) begin
      tx_valid_o <= 1'b1;
      tx_data_o  <= gcd_word;
      last_gcd   <= 1'b1;
    end else if (grant_sob) begin
      tx_valid_o <= 1'b1;
      tx_data_o  <= sob_word;
      last_gcd   <= 1'b0;
    end else if (tx_ack_i) begin
      tx_valid_o <= 1'b0;
    end
  end

  // --------------------------------------------------------------- GCD FSM
`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_fire;
  // Fires on the last allowed G_RUN cycle; a done in that cycle wins.
  assign wd_fire = (g_state == G_RUN) & ~gcd_done_i &
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // GCD control FSM with registered enable and busy outputs.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      g_state      <= G_IDLE;
      gcd_enable_o <= 1'b0;
      busy_o       <= 1'b0;
      result_q     <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      case (g_state)
        G_IDLE: begin
          if (start_cmd) begin
            g_state      <= G_RUN;
            gcd_enable_o <= 1'b1;
            busy_o       <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
            wd_cnt       <= '0;
`endif
          end
        end
        G_RUN: begin
          if (gcd_done_i) begin
            result_q     <= gcd_i;
            g_state      <= G_RESULT;
            gcd_enable_o <= 1'b0;
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          else if (wd_fire) begin
            g_state      <= G_IDLE;
            gcd_enable_o <= 1'b0;
            busy_o       <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        G_RESULT: begin
          if (grant_gcd) begin
            g_state <= G_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          g_state      <= G_IDLE;
          gcd_enable_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  // ----------------------------------------------------------- sticky flags
  // Overflow: a new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                  overflow_o <= 1'b0;
    else if (fifo_drop || sob_drop) overflow_o <= 1'b1;
    else if (clear_cmd)             overflow_o <= 1'b0;
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  // Watchdog flag, sticky until a clear command.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)      timeout_o <= 1'b0;
    else if (wd_fire)   timeout_o <= 1'b1;
    else if (clear_cmd) timeout_o <= 1'b0;
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule
